// File: rtl/memoria_lector_pkg.sv
// rtl/memoria_lector_pkg.sv - shared types and constants for the register-file burst reader
package memoria_lector_pkg;

    localparam int NUM_REGS = 16;
    localparam int ADDR_W   = 4;
    localparam int DEF_N    = 16;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Register index after a, wrapping the last register back to the first.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        return a + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/memoria_lector_if.sv
// rtl/memoria_lector_if.sv - request, register-file and output-stream bundle (dout_par under MEMORIA_LECTOR_PARITY_EN)
interface memoria_lector_if
    import memoria_lector_pkg::*;
#(
    parameter int N = DEF_N
);

    logic                   req;
    logic [ADDR_W-1:0]      start_addr;
    logic [ADDR_W-1:0]      burst_len;
    logic [NUM_REGS*N-1:0]  r_bus;
    logic [N-1:0]           dout;
    logic [ADDR_W-1:0]      dout_addr;
    logic                   dout_valid;
    logic                   dout_ready;
    logic                   busy;
    logic                   done;
`ifdef MEMORIA_LECTOR_PARITY_EN
    logic                   dout_par;
`endif

    modport master (
        input  req, start_addr, burst_len, r_bus, dout_ready,
        output dout, dout_addr, dout_valid, busy, done
`ifdef MEMORIA_LECTOR_PARITY_EN
        , output dout_par
`endif
    );

    modport slave (
        output req, start_addr, burst_len, r_bus, dout_ready,
        input  dout, dout_addr, dout_valid, busy, done
`ifdef MEMORIA_LECTOR_PARITY_EN
        , input dout_par
`endif
    );

endinterface

// File: rtl/memoria_lector_mux.sv
// rtl/memoria_lector_mux.sv - 16:1 word selector over the flattened register-file bus
module memoria_lector_mux
    import memoria_lector_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic [NUM_REGS*N-1:0] r_bus,
    input  logic [ADDR_W-1:0]     sel,
    output logic [N-1:0]          word
);

    always_comb begin
        word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (sel == ADDR_W'(i)) begin
                word = r_bus[i*N +: N];
            end
        end
    end

endmodule

// File: rtl/memoria_lector.sv
// rtl/memoria_lector.sv - burst reader streaming register-file words with valid/ready (MEMORIA_LECTOR_PARITY_EN adds dout_par)
module memoria_lector
    import memoria_lector_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic            clk,
    input  logic            rst,
    memoria_lector_if.master bus
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] rem_q, rem_d;
    logic [N-1:0]      dout_q, dout_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
`ifdef MEMORIA_LECTOR_PARITY_EN
    logic              par_q, par_d;
`endif

    logic [ADDR_W-1:0] sel;
    logic [N-1:0]      word;
    logic              xfer;

    // In IDLE the mux looks at the requested start; in SEND it prefetches the next index.
    assign sel  = (state_q == IDLE) ? bus.start_addr : next_addr(addr_q);
    assign xfer = valid_q & bus.dout_ready;

    memoria_lector_mux #(.N(N)) u_mux (
        .r_bus (bus.r_bus),
        .sel   (sel),
        .word  (word)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        dout_d  = dout_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef MEMORIA_LECTOR_PARITY_EN
        par_d   = par_q;
`endif
        if (state_q == IDLE) begin
            if (bus.req) begin
                state_d = SEND;
                addr_d  = bus.start_addr;
                rem_d   = bus.burst_len;
                dout_d  = word;
                valid_d = 1'b1;
                busy_d  = 1'b1;
`ifdef MEMORIA_LECTOR_PARITY_EN
                par_d   = ^word;
`endif
            end
        end else begin
            // dout only reloads on a transfer, so a stalled word is a stable snapshot.
            if (xfer) begin
                if (rem_q == '0) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    addr_d  = sel;
                    rem_d   = rem_q - ADDR_W'(1);
                    dout_d  = word;
`ifdef MEMORIA_LECTOR_PARITY_EN
                    par_d   = ^word;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef MEMORIA_LECTOR_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef MEMORIA_LECTOR_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_addr  = addr_q;
    assign bus.dout_valid = valid_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
`ifdef MEMORIA_LECTOR_PARITY_EN
    assign bus.dout_par   = par_q;
`endif

endmodule

// File: tb/tb_memoria_lector.sv
// tb/tb_memoria_lector.sv - directed self-checking bench for memoria_lector
module tb_memoria_lector;
    import memoria_lector_pkg::*;

    localparam int N = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    memoria_lector_if #(.N(N)) bus();

    memoria_lector #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [N-1:0] mem [NUM_REGS];
    int total = 0;
    int bad = 0;
    int xfer_cnt = 0;
    int base;
    logic [22:0] obs;
    logic [22:0] expv;
    logic [2:0]  flg;
    logic [15:0] visited;

    always_comb begin
        bus.r_bus = '0;
        for (int i = 0; i < NUM_REGS; i++) bus.r_bus[i*N +: N] = mem[i];
    end

    always @(posedge clk) begin
        if (!rst && bus.dout_valid && bus.dout_ready) xfer_cnt = xfer_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
        obs = {bus.dout_valid, bus.busy, bus.done, bus.dout_addr, bus.dout};
        flg = {bus.dout_valid, bus.busy, bus.done};
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req = 1'b0; bus.start_addr = '0; bus.burst_len = '0; bus.dout_ready = 1'b1;
        #2;
        obs = {bus.dout_valid, bus.busy, bus.done, bus.dout_addr, bus.dout};
        total++; if (obs !== 23'h0) begin bad++; $display("FAIL reset_async: got %h want %h", obs, 23'h0); end
`ifdef MEMORIA_LECTOR_PARITY_EN
        total++; if (bus.dout_par !== 1'b0) begin bad++; $display("FAIL reset_par: got %b want 0", bus.dout_par); end
`endif
        step();
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            total++; if (obs !== 23'h0) begin bad++; $display("FAIL reset_hold%0d: got %h want %h", c, obs, 23'h0); end
        end
    endtask

    task automatic test_single();
        mem[0] = 16'h0009;
        base = xfer_cnt;
        bus.start_addr = 4'd0; bus.burst_len = 4'd0; bus.dout_ready = 1'b1; bus.req = 1'b1;
        step();
        bus.req = 1'b0;
        expv = {1'b1, 1'b1, 1'b0, 4'd0, 16'h0009};
        total++; if (obs !== expv) begin bad++; $display("FAIL single_word: got %h want %h", obs, expv); end
        step();
        total++; if (flg !== 3'b001) begin bad++; $display("FAIL single_done: got %b want 001", flg); end
        step();
        total++; if (flg !== 3'b000) begin bad++; $display("FAIL single_idle: got %b want 000", flg); end
        total++; if (xfer_cnt - base !== 1) begin bad++; $display("FAIL single_count: got %0d want 1", xfer_cnt - base); end
    endtask

    task automatic test_wrap();
        base = xfer_cnt;
        bus.start_addr = 4'd14; bus.burst_len = 4'd3; bus.req = 1'b1;
        step();
        bus.req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            expv = {1'b1, 1'b1, 1'b0, 4'((14 + i) % 16), mem[(14 + i) % 16]};
            total++; if (obs !== expv) begin bad++; $display("FAIL wrap_word%0d: got %h want %h", i, obs, expv); end
            step();
        end
        total++; if (flg !== 3'b001) begin bad++; $display("FAIL wrap_done: got %b want 001", flg); end
        total++; if (xfer_cnt - base !== 4) begin bad++; $display("FAIL wrap_count: got %0d want 4", xfer_cnt - base); end
        step();
    endtask

    task automatic test_backpressure();
        mem[1] = 16'h0404;
        base = xfer_cnt;
        bus.start_addr = 4'd0; bus.burst_len = 4'd2; bus.req = 1'b1;
        step();
        bus.req = 1'b0;
        expv = {1'b1, 1'b1, 1'b0, 4'd0, mem[0]};
        total++; if (obs !== expv) begin bad++; $display("FAIL bp_word0: got %h want %h", obs, expv); end
        step();
        bus.dout_ready = 1'b0;
        mem[1] = 16'hFFFF;
        for (int c = 0; c < 3; c++) begin
            expv = {1'b1, 1'b1, 1'b0, 4'd1, 16'h0404};
            total++; if (obs !== expv) begin bad++; $display("FAIL bp_stall%0d: got %h want %h", c, obs, expv); end
            step();
        end
        expv = {1'b1, 1'b1, 1'b0, 4'd1, 16'h0404};
        total++; if (obs !== expv) begin bad++; $display("FAIL bp_stall_end: got %h want %h", obs, expv); end
        bus.dout_ready = 1'b1;
        step();
        expv = {1'b1, 1'b1, 1'b0, 4'd2, mem[2]};
        total++; if (obs !== expv) begin bad++; $display("FAIL bp_word2: got %h want %h", obs, expv); end
        step();
        total++; if (flg !== 3'b001) begin bad++; $display("FAIL bp_done: got %b want 001", flg); end
        total++; if (xfer_cnt - base !== 3) begin bad++; $display("FAIL bp_count: got %0d want 3", xfer_cnt - base); end
        step();
    endtask

    task automatic test_back_to_back();
        bus.start_addr = 4'd3; bus.burst_len = 4'd3; bus.req = 1'b1;
        step();
        bus.start_addr = 4'd9; bus.burst_len = 4'd0;
        for (int i = 0; i < 4; i++) begin
            expv = {1'b1, 1'b1, 1'b0, 4'(3 + i), mem[3 + i]};
            total++; if (obs !== expv) begin bad++; $display("FAIL b2b_word%0d: got %h want %h", i, obs, expv); end
            step();
        end
        total++; if (flg !== 3'b001) begin bad++; $display("FAIL b2b_done: got %b want 001", flg); end
        step();
        bus.req = 1'b0;
        expv = {1'b1, 1'b1, 1'b0, 4'd9, mem[9]};
        total++; if (obs !== expv) begin bad++; $display("FAIL b2b_restart: got %h want %h", obs, expv); end
        step();
        total++; if (flg !== 3'b001) begin bad++; $display("FAIL b2b_done2: got %b want 001", flg); end
        step();
    endtask

    task automatic test_full_burst();
        base = xfer_cnt;
        visited = '0;
        bus.start_addr = 4'd5; bus.burst_len = 4'd15; bus.req = 1'b1;
        step();
        bus.req = 1'b0;
        for (int i = 0; i < 16; i++) begin
            expv = {1'b1, 1'b1, 1'b0, 4'((5 + i) % 16), mem[(5 + i) % 16]};
            total++; if (obs !== expv) begin bad++; $display("FAIL full_word%0d: got %h want %h", i, obs, expv); end
            visited[bus.dout_addr] = 1'b1;
            step();
        end
        total++; if (visited !== 16'hFFFF) begin bad++; $display("FAIL full_visit: got %h want ffff", visited); end
        total++; if (xfer_cnt - base !== 16) begin bad++; $display("FAIL full_count: got %0d want 16", xfer_cnt - base); end
        total++; if (flg !== 3'b001) begin bad++; $display("FAIL full_done: got %b want 001", flg); end
        step();
    endtask

    task automatic test_async_reset();
        base = xfer_cnt;
        bus.start_addr = 4'd0; bus.burst_len = 4'd15; bus.req = 1'b1;
        step();
        bus.req = 1'b0;
        for (int i = 0; i < 4; i++) step();
        expv = {1'b1, 1'b1, 1'b0, 4'd4, mem[4]};
        total++; if (obs !== expv) begin bad++; $display("FAIL ar_word5: got %h want %h", obs, expv); end
        #2;
        rst = 1'b1;
        #1;
        obs = {bus.dout_valid, bus.busy, bus.done, bus.dout_addr, bus.dout};
        total++; if (obs !== 23'h0) begin bad++; $display("FAIL ar_clear: got %h want %h", obs, 23'h0); end
        step();
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            step();
            total++; if (obs !== 23'h0) begin bad++; $display("FAIL ar_nodone%0d: got %h want %h", c, obs, 23'h0); end
        end
        total++; if (xfer_cnt - base !== 4) begin bad++; $display("FAIL ar_count: got %0d want 4", xfer_cnt - base); end
    endtask

`ifdef MEMORIA_LECTOR_PARITY_EN
    task automatic test_parity();
        logic [2:0] pexp;
        pexp = 3'b100;
        mem[0] = 16'h8004; mem[1] = 16'hA204; mem[2] = 16'h0001;
        bus.start_addr = 4'd0; bus.burst_len = 4'd2; bus.req = 1'b1;
        step();
        bus.req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++; if (bus.dout_par !== pexp[i]) begin bad++; $display("FAIL parity%0d: got %b want %b", i, bus.dout_par, pexp[i]); end
            step();
        end
        step();
    endtask
`endif

    initial begin
        for (int i = 0; i < NUM_REGS; i++) mem[i] = 16'(16'hA050 + i * 16'h0101);
        test_reset();
        test_single();
        test_wrap();
        test_backpressure();
        test_back_to_back();
        test_full_burst();
        test_async_reset();
`ifdef MEMORIA_LECTOR_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
